// File: rtl/shared_counter_arbiter.sv
// Round-robin time-slice arbiter sharing one WIDTH-bit up-counter among NUM_REQ requesters.
// Optional timeout statistics output enabled by defining SHARED_COUNTER_ARB_STATS_EN.
module shared_counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int QUANTUM = 15,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] io_req,
  output logic [NUM_REQ-1:0] io_grant,
  output logic [ID_W-1:0]    io_grant_id,
  output logic [WIDTH-1:0]   io_value,
  output logic               io_busy,
`ifdef SHARED_COUNTER_ARB_STATS_EN
  output logic               io_timeout,
  output logic [7:0]         io_timeout_count
`else
  output logic               io_timeout
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  localparam logic [WIDTH-1:0] QUANTUM_V = WIDTH'(QUANTUM);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t               state_reg;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [ID_W-1:0]      grant_id_reg;
  logic [WIDTH-1:0]     value_reg;
  logic                 busy_reg;
  logic                 timeout_reg;
  logic [ID_W-1:0]      rr_ptr_reg;

  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [ID_W-1:0]      rr_next;

  // First requester at or above the rr pointer, wrapping past NUM_REQ-1.
  always_comb begin : arb_scan
    int idx;
    idx        = 0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && io_req[idx[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[ID_W-1:0];
      end
    end
    sel_onehot = NUM_REQ'(1) << sel_idx;
  end

  assign rr_next = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;

`ifdef SHARED_COUNTER_ARB_STATS_EN
  logic [7:0] timeout_count_reg;
  assign io_timeout_count = timeout_count_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      value_reg    <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      rr_ptr_reg   <= '0;
`ifdef SHARED_COUNTER_ARB_STATS_EN
      timeout_count_reg <= '0;
`endif
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          value_reg <= '0;
          if (sel_found) begin
            state_reg    <= ST_GRANT;
            grant_reg    <= sel_onehot;
            grant_id_reg <= sel_idx;
            busy_reg     <= 1'b1;
          end
        end
        ST_GRANT: begin
          // A dropped request takes precedence over the quantum limit.
          if (!io_req[grant_id_reg]) begin
            state_reg <= ST_RELEASE;
            grant_reg <= '0;
            busy_reg  <= 1'b0;
          end else if (value_reg == QUANTUM_V) begin
            state_reg   <= ST_RELEASE;
            grant_reg   <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b1;
`ifdef SHARED_COUNTER_ARB_STATS_EN
            if (timeout_count_reg != 8'hFF) timeout_count_reg <= timeout_count_reg + 8'd1;
`endif
          end else begin
            value_reg <= value_reg + 1'b1;
          end
        end
        ST_RELEASE: begin
          value_reg  <= '0;
          rr_ptr_reg <= rr_next;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign io_grant    = grant_reg;
  assign io_grant_id = grant_id_reg;
  assign io_value    = value_reg;
  assign io_busy     = busy_reg;
  assign io_timeout  = timeout_reg;

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Randomized bench for shared_counter_arbiter against a slot-level reference model.
// Checks io_timeout_count too when SHARED_COUNTER_ARB_STATS_EN is defined.
module tb_shared_counter_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int QUANTUM = 15;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] io_req = '0;
  logic [NUM_REQ-1:0] io_grant;
  logic [1:0]         io_grant_id;
  logic [WIDTH-1:0]   io_value;
  logic               io_busy;
  logic               io_timeout;
`ifdef SHARED_COUNTER_ARB_STATS_EN
  logic [7:0]         io_timeout_count;
`endif

  shared_counter_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .QUANTUM(QUANTUM)) dut (
    .clk(clk),
    .reset(reset),
    .io_req(io_req),
    .io_grant(io_grant),
    .io_grant_id(io_grant_id),
    .io_value(io_value),
    .io_busy(io_busy),
`ifdef SHARED_COUNTER_ARB_STATS_EN
    .io_timeout(io_timeout),
    .io_timeout_count(io_timeout_count)
`else
    .io_timeout(io_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slot-level model: who owns the counter, how long they have held it,
  // and whether we are in the single cooldown cycle after a slot ended.
  bit m_owned;
  bit m_cooldown;
  bit m_forced;
  int m_owner;
  int m_age;
  int m_rr;
  int m_end_val;
  int m_tcount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owned    = 1'b0;
    m_cooldown = 1'b0;
    m_forced   = 1'b0;
    m_owner    = 0;
    m_age      = 0;
    m_rr       = 0;
    m_end_val  = 0;
    m_tcount   = 0;
  endfunction

  function automatic void model_step(input logic [NUM_REQ-1:0] req);
    if (m_owned) begin
      if (req[m_owner] == 1'b0 || m_age == QUANTUM) begin
        m_forced   = (req[m_owner] == 1'b1);
        m_owned    = 1'b0;
        m_cooldown = 1'b1;
        m_end_val  = m_age;
        if (m_forced && m_tcount < 255) m_tcount++;
        $display("slot owner=%0d cycles=%0d forced=%0d", m_owner, m_age + 1, m_forced);
      end else begin
        m_age++;
      end
    end else if (m_cooldown) begin
      m_cooldown = 1'b0;
      m_rr       = (m_owner + 1) % NUM_REQ;
    end else if (req != 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!m_owned && req[(m_rr + k) % NUM_REQ]) begin
          m_owner = (m_rr + k) % NUM_REQ;
          m_owned = 1'b1;
          m_age   = 0;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    check("grant",    32'(io_grant),    m_owned ? (32'd1 << m_owner) : 32'd0);
    check("grant_id", 32'(io_grant_id), 32'(m_owner));
    check("value",    32'(io_value),    m_owned ? 32'(m_age) : (m_cooldown ? 32'(m_end_val) : 32'd0));
    check("busy",     32'(io_busy),     32'(m_owned));
    check("timeout",  32'(io_timeout),  32'(m_cooldown && m_forced));
`ifdef SHARED_COUNTER_ARB_STATS_EN
    check("timeout_count", 32'(io_timeout_count), 32'(m_tcount));
`endif
  endtask

  task automatic run_cycle(input logic [NUM_REQ-1:0] req);
    @(negedge clk);
    check_outputs();
    io_req = req;
    @(posedge clk);
    model_step(req);
  endtask

  // mode 0: fresh random each cycle; mode 1: sticky bits with rare toggles.
  function automatic logic [NUM_REQ-1:0] next_req(input int mode, input logic [NUM_REQ-1:0] cur);
    logic [NUM_REQ-1:0] r;
    r = cur;
    if (mode == 0) begin
      r = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
    end else begin
      for (int b = 0; b < NUM_REQ; b++)
        if ($urandom_range(0, 23) == 0) r[b] = ~r[b];
    end
    // Exercise the drop-at-quantum tie where the drop must win.
    if (m_owned && m_age == QUANTUM && $urandom_range(0, 1) == 1) r[m_owner] = 1'b0;
    return r;
  endfunction

  initial begin
    logic [NUM_REQ-1:0] r;
    bit reached;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (10) run_cycle('0);
    repeat (3) run_cycle(4'b0100);
    repeat (4) run_cycle(4'b0000);
    repeat (40) run_cycle(4'b0010);
    run_cycle(4'b0000);
    repeat (3) run_cycle(4'b0000);
    repeat (80) run_cycle(4'b1111);

    r = '0;
    for (int i = 0; i < 1500; i++) begin
      r = next_req(1, r);
      run_cycle(r);
    end
    for (int i = 0; i < 400; i++) begin
      r = next_req(0, r);
      run_cycle(r);
    end

    // Reset in the middle of a slot once the counter shows 7.
    repeat (4) run_cycle('0);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      run_cycle(4'b0100);
      if (m_owned && m_age == 7) reached = 1'b1;
    end
    check("reach_value7", 32'(reached), 32'd1);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    #1;
    check("rst_grant",    32'(io_grant),    32'd0);
    check("rst_value",    32'(io_value),    32'd0);
    check("rst_busy",     32'(io_busy),     32'd0);
    check("rst_timeout",  32'(io_timeout),  32'd0);
    check("rst_grant_id", 32'(io_grant_id), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    io_req = '0;
    reset  = 1'b0;
    repeat (6) run_cycle(4'b1000);
    repeat (3) run_cycle(4'b0000);

    // Three back-to-back forced releases for one requester.
    repeat (3 * 18) run_cycle(4'b0010);
    repeat (3) run_cycle(4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shared_counter_arbiter.md
Name: shared_counter_arbiter

Overview:
Round-robin time-slice arbiter that shares one WIDTH-bit up-counter among NUM_REQ requesters. It grants the counter to one requester at a time, clears the counter at grant start, and counts the cycles of ownership. Ownership ends when the owner drops its request or the slot reaches QUANTUM. It sits between client blocks and the shared counter datapath, and sequences its clear and increment.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, counter width in bits
QUANTUM, 15, maximum counter value per slot before forced release (1..2^WIDTH-1)

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
io_req  input  NUM_REQ  per-requester request level; bit i held high while requester i wants the counter
io_grant  output  NUM_REQ  one-hot grant; all zero when idle
io_grant_id  output  clog2(NUM_REQ)  index of current owner; holds last owner when idle
io_value  output  WIDTH  shared counter value
io_busy  output  1  high while in GRANT state
io_timeout  output  1  one-cycle pulse on forced release at QUANTUM

Behaviour:
- Reset values: io_grant=0, io_grant_id=0, io_value=0, io_busy=0, io_timeout=0, rr pointer=0, state=IDLE.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If io_req != 0, select the first set bit searching upward from the rr pointer, with wrap-around.
  - Next cycle: state=GRANT, io_grant=onehot(sel), io_grant_id=sel, counter=0.
  - Grant latency is 1 cycle from the sampled request.
- GRANT: the counter increments by 1 each cycle (modulo 2^WIDTH; it never wraps in practice because QUANTUM ≤ 2^WIDTH-1).
- GRANT exits, in priority order:
  - (a) io_req[owner]==0: next state=RELEASE; counter holds its value; io_timeout stays 0.
  - (b) counter==QUANTUM: next state=RELEASE; io_timeout=1 for exactly the first RELEASE cycle.
  - If both conditions hold in the same cycle, (a) wins and no timeout is raised.
- RELEASE (exactly 1 cycle):
  - io_grant=0 and io_busy=0.
  - rr pointer = (owner+1) mod NUM_REQ.
  - Counter is cleared to 0 at the end of the cycle.
  - Next state=IDLE.
- Turnaround: minimum 2 non-granted cycles (RELEASE, IDLE) between consecutive grants.
- Requests from non-owners during GRANT are ignored; they are evaluated only in IDLE.
- The owner re-asserting its request after release is served again only after any other pending requester, per round-robin order.
- io_value reflects the registered counter value. It equals the cycle count of the current slot (0 on the first granted cycle).
- Counter value 2^WIDTH-1 is the full value. QUANTUM=2^WIDTH-1 therefore means release on full.
- An asynchronous reset mid-slot forces IDLE immediately, clears all outputs and the rr pointer, and raises no timeout pulse.

Optional Feature:
- Macro: SHARED_COUNTER_ARB_STATS_EN.
- When defined: adds output io_timeout_count, 8 bits, counting io_timeout pulses.
  - Saturates at 255.
  - Reset to 0.
  - Unaffected by normal releases.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then io_req=0 for 10 cycles -> io_grant=0, io_busy=0, io_value=0, io_timeout=0 throughout.
- io_req=4'b0100 held 3 cycles then dropped -> io_grant=4'b0100 from cycle+1, io_value 0,1,2, then RELEASE with io_grant=0, io_timeout=0; next grant search starts at index 3.
- io_req=4'b0010 held continuously, QUANTUM=15 -> io_value counts 0..15, 1-cycle io_timeout pulse, io_grant=0 for 2 cycles, then re-granted to requester 1 with io_value=0.
- io_req=4'b1111 held -> grants rotate 0,1,2,3,0 with exactly 2 idle cycles between slots; each slot lasts 16 cycles.
- io_req[owner] dropped in the same cycle io_value==QUANTUM -> release with io_timeout=0 (priority (a)).
- Reset asserted mid-slot at io_value=7 -> outputs zero immediately; after reset release, io_req=4'b1000 is granted to index 3 with rr starting from 0; with SHARED_COUNTER_ARB_STATS_EN, three forced timeouts -> io_timeout_count=3.
